// File: rtl/mul_share_ctrl.sv
// Two-port round-robin front end for one shared, non-stalling 16x16 multiplier.
// Tracks in-flight ops and returns each tagged product to its requester.
module mul_share_ctrl #(
  parameter int LAT  = 3,
  parameter int TAGW = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req0_valid,
  input  logic            req1_valid,
  output logic            req0_ready,
  output logic            req1_ready,
  input  logic [15:0]     req0_a,
  input  logic [15:0]     req0_b,
  input  logic [15:0]     req1_a,
  input  logic [15:0]     req1_b,
  input  logic [TAGW-1:0] req0_tag,
  input  logic [TAGW-1:0] req1_tag,
  input  logic            flush,
  output logic [15:0]     mul_a,
  output logic [15:0]     mul_b,
  input  logic [31:0]     mul_p,
  output logic            rsp0_valid,
  output logic            rsp1_valid,
  output logic [31:0]     rsp0_p,
  output logic [31:0]     rsp1_p,
  output logic [TAGW-1:0] rsp0_tag,
  output logic [TAGW-1:0] rsp1_tag,
  output logic [3:0]      inflight
);

  logic            pref1;
  logic [LAT:0]    pv;
  logic [LAT:0]    pport;
  logic [TAGW-1:0] ptag [LAT+1];
  logic            acc;
  logic            sel1;
  logic            tail;

  assign req0_ready = !flush && req0_valid
                   && (!req1_valid || !pref1);
  assign req1_ready = !flush && req1_valid
                   && (!req0_valid || pref1);
  assign acc  = req0_ready || req1_ready;
  assign sel1 = req1_ready;
  // tail entry lines up with mul_p for its operands
  assign tail = pv[LAT] && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pref1      <= 1'b0;
      pv         <= '0;
      pport      <= '0;
      for (int i = 0; i <= LAT; i++)
        ptag[i] <= '0;
      mul_a      <= '0;
      mul_b      <= '0;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp0_p     <= '0;
      rsp1_p     <= '0;
      rsp0_tag   <= '0;
      rsp1_tag   <= '0;
      inflight   <= '0;
    end else begin
      if (flush)
        pv <= '0;
      else
        pv <= {pv[LAT-1:0], acc};
      pport   <= {pport[LAT-1:0], sel1};
      ptag[0] <= sel1 ? req1_tag : req0_tag;
      for (int i = 1; i <= LAT; i++)
        ptag[i] <= ptag[i-1];
      if (acc) begin
        mul_a <= sel1 ? req1_a : req0_a;
        mul_b <= sel1 ? req1_b : req0_b;
        pref1 <= !sel1;
      end
      rsp0_valid <= tail && !pport[LAT];
      rsp1_valid <= tail && pport[LAT];
      if (tail && pport[LAT]) begin
        rsp1_p   <= mul_p;
        rsp1_tag <= ptag[LAT];
      end
      if (tail && !pport[LAT]) begin
        rsp0_p   <= mul_p;
        rsp0_tag <= ptag[LAT];
      end
      if (flush)
        inflight <= '0;
      else
        inflight <= inflight + 4'(acc) - 4'(pv[LAT]);
    end
  end

endmodule

// File: doc/mul_share_ctrl.md
MUL_SHARE_CTRL -- requirements
Module: mul_share_ctrl

Interface
REQ-001 SHALL have parameter LAT, default 3: cycles from mul_a/mul_b change to matching mul_p valid; legal range 1..8.
REQ-002 SHALL have parameter TAGW, default 4: requester tag width.
REQ-003 SHALL have port clk, input, 1, single clock; all state on rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have ports req0_valid/req1_valid, input, 1 each, operand pair offered.
REQ-006 SHALL have ports req0_ready/req1_ready, output, 1 each, grant this cycle.
REQ-007 SHALL have ports req0_a, req0_b, req1_a, req1_b, input, 16 each, multiplicand and multiplier.
REQ-008 SHALL have ports req0_tag/req1_tag, input, TAGW each, returned with the result.
REQ-009 SHALL have port flush, input, 1, synchronous kill of all in-flight ops.
REQ-010 SHALL have ports mul_a/mul_b, output, 16 each, registered operands to the shared 16x16 multiplier.
REQ-011 SHALL have port mul_p, input, 32, multiplier product.
REQ-012 SHALL have ports rsp0_valid/rsp1_valid, output, 1 each, one-cycle result strobe.
REQ-013 SHALL have ports rsp0_p/rsp1_p, output, 32 each, and rsp0_tag/rsp1_tag, output, TAGW each.
REQ-014 SHALL have port inflight, output, 4, count of accepted, not-yet-responded ops.

Function
REQ-015 SHALL accept at most one request per cycle; transfer occurs when reqX_valid && reqX_ready at a rising edge.
REQ-016 SHALL compute reqX_ready combinationally: only one requester valid -> that one ready; both valid -> round-robin winner ready; neither valid -> both low.
REQ-017 SHALL prefer, when both valid, the port not granted on the most recent transfer; the pointer updates only on a transfer.
REQ-018 SHALL hold all readies low in any cycle where flush is high.
REQ-019 SHALL register the winner's a/b into mul_a/mul_b on transfer; with no transfer, mul_a/mul_b hold their previous value.
REQ-020 SHALL track each op in a LAT-stage pipeline of {valid, port, tag} advancing every cycle unconditionally; the multiplier cannot stall.
REQ-021 SHALL capture mul_p into rspX_p at the edge where the pipeline tail is valid, so an op accepted at edge N gives rspX_valid high for exactly the cycle after edge N+LAT+1.
REQ-022 SHALL assert only the rsp port matching the stored port bit; the other rsp_valid stays low, and its p/tag hold.
REQ-023 SHALL return tag unchanged with its own product; responses leave in acceptance order, with no reordering.
REQ-024 SHALL sustain one accept and one response per cycle back-to-back with no bubbles.
REQ-025 SHALL keep inflight = accepts minus responses, maximum LAT+1; simultaneous accept and response leaves it unchanged.
REQ-026 SHALL, on flush at edge F, clear all pipeline valid bits and the response stage: no rsp_valid after F, inflight = 0 after F, and any request also offered at F is not accepted.
REQ-027 SHALL not alter mul_a/mul_b on flush.

Reset
REQ-028 SHALL, while rst_n is low, force: rsp*_valid = 0, rsp*_p = 0, rsp*_tag = 0, mul_a = mul_b = 0, inflight = 0, all pipeline valids 0, and the RR pointer to prefer port 0.
REQ-029 SHALL take reset asynchronously, dropping any in-flight op with no response after release.
REQ-030 SHALL begin accepting on the first rising edge after rst_n deasserts.

Verification
REQ-031 Single op: after reset, req0 a=32, b=64, tag=5 for one cycle -> rsp0_valid for one cycle LAT+1 cycles later, rsp0_p=0x00000800, rsp0_tag=5, rsp1_valid never high.
REQ-032 Contention: both valid every cycle with distinct tags -> grants alternate 0,1,0,1; responses arrive in that order, one per cycle; inflight saturates at LAT+1.
REQ-033 Corner value: req1 a=0xFFFF, b=0xFFFF -> rsp1_p=0xFFFE0001; a=0, b=0xDD79 -> rsp_p=0.
REQ-034 Flush: accept 3 ops back-to-back, assert flush one cycle after the third -> no rsp_valid afterwards, inflight=0; a new op issued next cycle completes normally.
REQ-035 Reset mid-operation: drop rst_n with 2 ops in flight -> outputs zero immediately (no clock); no stale response after release; first post-reset grant goes to port 0 when both are valid.
REQ-036 Scoreboard checker: random valid on both ports with random operands for 10k cycles -> every accepted op yields exactly one response on its own port with a*b and the matching tag, in order.
